// File: rtl/xbar_ingress_scheduler.sv
// xbar_ingress_scheduler
//   Crossbar ingress stage for one line card. Each frame's TDEST
//   ({broadcast, global dest port}) is turned into a crossbar egress-port
//   mask, which is requested from the crossbar arbiter. Once granted, the
//   frame streams through a 2-entry registered skid buffer and the grant is
//   released one cycle after the last output beat. Frames with an invalid
//   destination, or that are never granted, are drained and counted.
//
// Ports
//   clk, areset_n              fabric clock, async active-low reset
//   s_t*                       AXI-Stream style input (data/keep/last/user/dest)
//   req_valid, req_mask        level request of an egress-port mask
//   grant                      arbiter grant, looked at only while requesting
//   release_pulse              one-cycle pulse freeing the granted paths
//                              ("release" is a reserved word)
//   m_t*                       AXI-Stream style output, tdest = egress mask,
//                              tid = our own crossbar port
//   drop_timeout_count         saturating count of grant-timeout drops
//   drop_invalid_count         saturating count of bad-destination drops
module xbar_ingress_scheduler #(
  parameter int NUM_PORTS      = 50,
  parameter int PORTS_PER_CARD = 24,
  parameter int NUM_XBAR_PORTS = 3,
  parameter int XBAR_PORT      = 0,
  parameter int GRANT_TIMEOUT  = 1023,
  localparam int PORT_BITS     = $clog2(NUM_PORTS),
  localparam int TID_BITS      = (NUM_XBAR_PORTS > 1) ? $clog2(NUM_XBAR_PORTS) : 1
) (
  input  logic                      clk,
  input  logic                      areset_n,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [63:0]               s_tdata,
  input  logic [7:0]                s_tkeep,
  input  logic                      s_tlast,
  input  logic [11:0]               s_tuser,
  input  logic [PORT_BITS:0]        s_tdest,
  output logic                      req_valid,
  output logic [NUM_XBAR_PORTS-1:0] req_mask,
  input  logic                      grant,
  output logic                      release_pulse,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [63:0]               m_tdata,
  output logic [7:0]                m_tkeep,
  output logic                      m_tlast,
  output logic [11:0]               m_tuser,
  output logic [NUM_XBAR_PORTS-1:0] m_tdest,
  output logic [TID_BITS-1:0]       m_tid,
  output logic [31:0]               drop_timeout_count,
  output logic [31:0]               drop_invalid_count
);

  localparam int TMR_BITS = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_FORWARD = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DROP    = 3'd4
  } state_t;

  // One-hot mask of the crossbar port serving a (valid) global dest port.
  function automatic logic [NUM_XBAR_PORTS-1:0] port_mask(input logic [PORT_BITS-1:0] dest);
    logic [NUM_XBAR_PORTS-1:0] m;
    int unsigned               idx;
    idx = 32'(dest) / 32'(PORTS_PER_CARD);
    for (int i = 0; i < NUM_XBAR_PORTS; i++) begin
      m[i] = (idx == 32'(i));
    end
    return m;
  endfunction

  // Counter increment that sticks at all ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  state_t                    state_q, state_d;
  logic [NUM_XBAR_PORTS-1:0] mask_q, mask_d;
  logic [11:0]               vlan_q, vlan_d;
  logic [TMR_BITS-1:0]       timer_q, timer_d;
  logic                      last_in_q, last_in_d;
  logic                      s_tready_q, s_tready_d;
  logic                      req_valid_q, req_valid_d;
  logic                      release_q, release_d;
  logic                      m_valid_q, m_valid_d;
  logic [63:0]               m_data_q, m_data_d;
  logic [7:0]                m_keep_q, m_keep_d;
  logic                      m_last_q, m_last_d;
  logic                      sk_valid_q, sk_valid_d;
  logic [63:0]               sk_data_q, sk_data_d;
  logic [7:0]                sk_keep_q, sk_keep_d;
  logic                      sk_last_q, sk_last_d;
  logic [31:0]               drop_to_q, drop_to_d;
  logic [31:0]               drop_inv_q, drop_inv_d;
  logic                      in_fire_s;
  logic                      out_fire_s;

  // Next-state, skid-buffer and counter logic.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    vlan_d      = vlan_q;
    timer_d     = timer_q;
    last_in_d   = last_in_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_last_d    = m_last_q;
    sk_valid_d  = sk_valid_q;
    sk_data_d   = sk_data_q;
    sk_keep_d   = sk_keep_q;
    sk_last_d   = sk_last_q;
    drop_to_d   = drop_to_q;
    drop_inv_d  = drop_inv_q;
    in_fire_s   = s_tvalid & s_tready_q;
    out_fire_s  = m_valid_q & m_tready;

    case (state_q)
      ST_IDLE: begin
        timer_d   = '0;
        last_in_d = 1'b0;
        // The head beat is only inspected here; it is consumed later.
        if (s_tvalid) begin
          vlan_d = s_tuser;
          if (s_tdest[PORT_BITS]) begin
            mask_d  = '1;
            state_d = ST_REQUEST;
          end else if (32'(s_tdest[PORT_BITS-1:0]) < 32'(NUM_PORTS)) begin
            mask_d  = port_mask(s_tdest[PORT_BITS-1:0]);
            state_d = ST_REQUEST;
          end else begin
            mask_d     = '0;
            state_d    = ST_DROP;
            drop_inv_d = sat_inc(drop_inv_q);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQUEST: begin
        // Grant takes priority over a coincident timeout.
        if (grant) begin
          state_d = ST_FORWARD;
        end else if (timer_q == TMR_BITS'(GRANT_TIMEOUT - 1)) begin
          state_d   = ST_DROP;
          drop_to_d = sat_inc(drop_to_q);
        end else begin
          timer_d = timer_q + TMR_BITS'(1);
        end
      end
      ST_FORWARD: begin
        // Drain side first: refill the output stage from the skid entry.
        if (out_fire_s) begin
          if (sk_valid_q) begin
            m_data_d   = sk_data_q;
            m_keep_d   = sk_keep_q;
            m_last_d   = sk_last_q;
            sk_valid_d = 1'b0;
          end else begin
            m_valid_d = 1'b0;
          end
        end else begin
          m_valid_d = m_valid_q;
        end
        // Fill side: an input beat goes to the output stage if it is free
        // after the drain above, otherwise into the skid entry.
        if (in_fire_s) begin
          last_in_d = last_in_q | s_tlast;
          if (!m_valid_d) begin
            m_valid_d = 1'b1;
            m_data_d  = s_tdata;
            m_keep_d  = s_tkeep;
            m_last_d  = s_tlast;
          end else begin
            sk_valid_d = 1'b1;
            sk_data_d  = s_tdata;
            sk_keep_d  = s_tkeep;
            sk_last_d  = s_tlast;
          end
        end else begin
          last_in_d = last_in_q;
        end
        if (out_fire_s && m_last_q) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_FORWARD;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      ST_DROP: begin
        if (in_fire_s && s_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake/request outputs are registered from the next state so they
    // line up with the state they describe.
    s_tready_d  = ((state_d == ST_FORWARD) && !sk_valid_d && !last_in_d) ||
                  (state_d == ST_DROP);
    req_valid_d = (state_d == ST_REQUEST);
    release_d   = (state_d == ST_RELEASE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      vlan_q      <= 12'd0;
      timer_q     <= '0;
      last_in_q   <= 1'b0;
      s_tready_q  <= 1'b0;
      req_valid_q <= 1'b0;
      release_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= 64'd0;
      m_keep_q    <= 8'd0;
      m_last_q    <= 1'b0;
      sk_valid_q  <= 1'b0;
      sk_data_q   <= 64'd0;
      sk_keep_q   <= 8'd0;
      sk_last_q   <= 1'b0;
      drop_to_q   <= 32'd0;
      drop_inv_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      vlan_q      <= vlan_d;
      timer_q     <= timer_d;
      last_in_q   <= last_in_d;
      s_tready_q  <= s_tready_d;
      req_valid_q <= req_valid_d;
      release_q   <= release_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
      sk_valid_q  <= sk_valid_d;
      sk_data_q   <= sk_data_d;
      sk_keep_q   <= sk_keep_d;
      sk_last_q   <= sk_last_d;
      drop_to_q   <= drop_to_d;
      drop_inv_q  <= drop_inv_d;
    end
  end

  assign s_tready           = s_tready_q;
  assign req_valid          = req_valid_q;
  assign req_mask           = mask_q;
  assign release_pulse      = release_q;
  assign m_tvalid           = m_valid_q;
  assign m_tdata            = m_data_q;
  assign m_tkeep            = m_keep_q;
  assign m_tlast            = m_last_q;
  assign m_tuser            = vlan_q;
  assign m_tdest            = mask_q;
  assign m_tid              = TID_BITS'(XBAR_PORT);
  assign drop_timeout_count = drop_to_q;
  assign drop_invalid_count = drop_inv_q;

endmodule

// File: tb/tb_xbar_ingress_scheduler.sv
module tb_xbar_ingress_scheduler;
  localparam int NP = 50;
  localparam int PB = $clog2(NP);
  localparam int GT = 1023;

  logic          clk = 1'b0;
  logic          areset_n = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [63:0]   s_tdata = 64'd0;
  logic [7:0]    s_tkeep = 8'd0;
  logic          s_tlast = 1'b0;
  logic [11:0]   s_tuser = 12'd0;
  logic [PB:0]   s_tdest = '0;
  logic          req_valid;
  logic [2:0]    req_mask;
  logic          grant = 1'b0;
  logic          release_pulse;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic          m_tlast;
  logic [11:0]   m_tuser;
  logic [2:0]    m_tdest;
  logic [1:0]    m_tid;
  logic [31:0]   drop_timeout_count;
  logic [31:0]   drop_invalid_count;

  xbar_ingress_scheduler dut (
    .clk(clk), .areset_n(areset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tdest(s_tdest),
    .req_valid(req_valid), .req_mask(req_mask), .grant(grant), .release_pulse(release_pulse),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tdest(m_tdest), .m_tid(m_tid),
    .drop_timeout_count(drop_timeout_count), .drop_invalid_count(drop_invalid_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [11:0] u;
    logic [2:0]  m;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    req_cyc = 0;
  int    rel_cnt = 0;
  int    since_rel = 1000;
  bit    prev_req = 1'b0;
  bit    prev_stall = 1'b0;
  bit    prev_last_hs = 1'b0;
  bit    quiet = 1'b0;
  beat_t held;

  // Output monitor / scoreboard, sampled on the inactive edge.
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur.d = m_tdata; cur.k = m_tkeep; cur.l = m_tlast; cur.u = m_tuser; cur.m = m_tdest;
    if (areset_n) begin
      if (release_pulse) begin
        rel_cnt++;
        since_rel = 0;
        total++;
        if (!prev_last_hs) begin
          bad++; $display("FAIL release_timing got=release without preceding tlast handshake");
        end
      end else if (since_rel < 1000) begin
        since_rel++;
      end
      if (req_valid) req_cyc++;
      if (req_valid && !prev_req) begin
        total++;
        if (since_rel < 2) begin
          bad++; $display("FAIL req_gap got=%0d want>=2", since_rel);
        end
      end
      prev_req = req_valid;
      if (prev_stall) begin
        total++;
        if (m_tvalid !== 1'b1 || cur !== held) begin
          bad++; $display("FAIL stall_stable got=%0b/%h want=1/%h", m_tvalid, cur, held);
        end
      end
      if (quiet) begin
        total++;
        if (m_tvalid !== 1'b0) begin
          bad++; $display("FAIL quiet_mvalid got=%0b want=0", m_tvalid);
        end
      end
      if (m_tvalid && m_tready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL beat_extra got=%h want=none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            bad++; $display("FAIL beat got=%h want=%h", cur, e);
          end
        end
      end
      prev_last_hs = m_tvalid && m_tready && m_tlast;
      prev_stall   = m_tvalid && !m_tready;
      held         = cur;
    end else begin
      prev_req = 1'b0; prev_stall = 1'b0; prev_last_hs = 1'b0;
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic push, input logic [11:0] u, input logic [2:0] m);
    bit    acc = 1'b0;
    int    n = 0;
    beat_t b;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
    b.d = d; b.k = k; b.l = l; b.u = u; b.m = m;
    if (push) exp_q.push_back(b);
    while (!acc && n < 3000) begin
      @(negedge clk); acc = s_tready; @(posedge clk); #1; n++;
    end
    total++;
    if (!acc) begin
      bad++; $display("FAIL src_accept got=no accept want=accept within 3000");
    end
  endtask

  task automatic send_frame(input logic bc, input int dest, input logic [11:0] vlan,
                            input int nb, input logic fwd, input logic [2:0] m);
    logic [PB-1:0] dv;
    dv = dest[PB-1:0];
    s_tdest = {bc, dv};
    s_tuser = vlan;
    for (int i = 0; i < nb; i++) begin
      send_beat({$urandom, $urandom}, (i == nb - 1) ? 8'($urandom_range(1, 255)) : 8'hFF,
                (i == nb - 1), fwd, vlan, m);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  // Arbiter model: gdelay>=0 grants that many cycles after req_valid, -1 never grants.
  task automatic arbiter(input int gdelay, input logic [2:0] exp_mask);
    int n = 0;
    int c = 0;
    do begin @(negedge clk); n++; end while (!req_valid && n < 200);
    total++;
    if (!req_valid) begin
      bad++; $display("FAIL req_wait got=0 want=req_valid"); return;
    end
    total++;
    if (req_mask !== exp_mask) begin
      bad++; $display("FAIL req_mask got=%b want=%b", req_mask, exp_mask);
    end
    if (gdelay < 0) begin
      while (req_valid && c < 3000) begin c++; @(negedge clk); end
      total++;
      if (c != GT) begin
        bad++; $display("FAIL timeout_cycles got=%0d want=%0d", c, GT);
      end
    end else begin
      repeat (gdelay) @(posedge clk);
      #1 grant = 1'b1;
      @(posedge clk); #1 grant = 1'b0;
      @(negedge clk);
      total++;
      if (s_tready !== 1'b1) begin
        bad++; $display("FAIL grant_tready got=%b want=1", s_tready);
      end
      @(negedge clk);
      total++;
      if (m_tvalid !== 1'b1) begin
        bad++; $display("FAIL grant_mvalid got=%b want=1", m_tvalid);
      end
    end
  endtask

  // gdelay -2: no request expected, arbiter not run.
  task automatic run_frame(input logic bc, input int dest, input logic [11:0] vlan, input int nb,
                           input int gdelay, input logic fwd, input logic [2:0] m);
    int r0;
    int n = 0;
    @(posedge clk); #1;
    r0 = rel_cnt;
    fork
      send_frame(bc, dest, vlan, nb, fwd, m);
      begin if (gdelay != -2) arbiter(gdelay, m); end
    join
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain got=%0d left want=0", exp_q.size());
    end
    exp_q.delete();
    total++;
    if (rel_cnt - r0 != (fwd ? 1 : 0)) begin
      bad++; $display("FAIL release_count got=%0d want=%0d", rel_cnt - r0, fwd ? 1 : 0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if ({s_tready, req_valid, req_mask, release_pulse, m_tvalid} !== 7'd0) begin
      bad++; $display("FAIL %s_ctrl got=%b want=0", tag,
                      {s_tready, req_valid, req_mask, release_pulse, m_tvalid});
    end
    total++;
    if ({m_tdata, m_tkeep, m_tlast, m_tuser, m_tdest} !== 88'd0) begin
      bad++; $display("FAIL %s_mdata got=%h want=0", tag, {m_tdata, m_tkeep, m_tlast, m_tuser, m_tdest});
    end
    total++;
    if ({drop_timeout_count, drop_invalid_count} !== 64'd0) begin
      bad++; $display("FAIL %s_counters got=%h want=0", tag, {drop_timeout_count, drop_invalid_count});
    end
  endtask

  task automatic test_reset;
    #12;
    check_reset_values("reset");
    total++;
    if (m_tid !== 2'd0) begin
      bad++; $display("FAIL m_tid got=%0d want=0", m_tid);
    end
    @(negedge clk); areset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_unicast;
    run_frame(1'b0, 30, 12'd5, 8, 3, 1'b1, 3'b010);
    run_frame(1'b0, 49, 12'd9, 1, 0, 1'b1, 3'b100);
    run_frame(1'b0, 47, 12'd1, 2, 1, 1'b1, 3'b010);
    run_frame(1'b0, 10, 12'd2, 3, 2, 1'b1, 3'b001);
  endtask

  task automatic test_broadcast;
    run_frame(1'b1, 0, 12'd77, 5, 2, 1'b1, 3'b111);
    run_frame(1'b1, 55, 12'd78, 2, 0, 1'b1, 3'b111);
  endtask

  task automatic test_invalid;
    int r0;
    r0 = req_cyc;
    quiet = 1'b1;
    run_frame(1'b0, 55, 12'd3, 4, -2, 1'b0, 3'b000);
    total++;
    if (drop_invalid_count !== 32'd1) begin
      bad++; $display("FAIL invalid_count got=%0d want=1", drop_invalid_count);
    end
    run_frame(1'b0, 50, 12'd4, 1, -2, 1'b0, 3'b000);
    quiet = 1'b0;
    total++;
    if (drop_invalid_count !== 32'd2) begin
      bad++; $display("FAIL invalid_count2 got=%0d want=2", drop_invalid_count);
    end
    total++;
    if (req_cyc != r0) begin
      bad++; $display("FAIL invalid_req got=%0d cycles want=0", req_cyc - r0);
    end
  endtask

  task automatic test_timeout;
    run_frame(1'b0, 5, 12'd6, 3, -1, 1'b0, 3'b001);
    total++;
    if (drop_timeout_count !== 32'd1) begin
      bad++; $display("FAIL timeout_count got=%0d want=1", drop_timeout_count);
    end
    run_frame(1'b0, 20, 12'd8, 2, 2, 1'b1, 3'b001);
    total++;
    if (drop_timeout_count !== 32'd1) begin
      bad++; $display("FAIL timeout_count_after got=%0d want=1", drop_timeout_count);
    end
  endtask

  task automatic test_backpressure;
    bit stop = 1'b0;
    fork
      begin run_frame(1'b0, 33, 12'd100, 100, 1, 1'b1, 3'b010); stop = 1'b1; end
      begin
        while (!stop) begin @(posedge clk); #1 m_tready = 1'($urandom_range(0, 1)); end
        m_tready = 1'b1;
      end
    join
  endtask

  task automatic test_back_to_back;
    int r0;
    int n = 0;
    r0 = rel_cnt;
    @(posedge clk); #1;
    fork
      begin
        send_frame(1'b0, 2, 12'd11, 3, 1'b1, 3'b001);
        send_frame(1'b0, 26, 12'd12, 2, 1'b1, 3'b010);
      end
      begin arbiter(0, 3'b001); arbiter(0, 3'b010); end
    join
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || rel_cnt - r0 != 2) begin
      bad++; $display("FAIL b2b got=%0d left/%0d rel want=0/2", exp_q.size(), rel_cnt - r0);
    end
    exp_q.delete();
  endtask

  task automatic test_mid_reset;
    @(posedge clk); #1;
    s_tdest = {1'b0, 6'd40}; s_tuser = 12'd7;
    fork
      begin
        for (int i = 0; i < 4; i++) send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b1, 12'd7, 3'b010);
      end
      arbiter(1, 3'b010);
    join
    s_tvalid = 1'b0;
    #1 areset_n = 1'b0;
    #1 check_reset_values("midreset");
    repeat (3) @(negedge clk);
    exp_q.delete();
    areset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(1'b0, 12, 12'd21, 4, 1, 1'b1, 3'b001);
  endtask

  initial begin
    test_reset;
    test_unicast;
    test_broadcast;
    test_invalid;
    test_timeout;
    test_backpressure;
    test_back_to_back;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xbar_ingress_scheduler.md
# xbar_ingress_scheduler

Per-line-card crossbar ingress stage that sits directly downstream of the line-card input buffering block. It takes each 64-bit frame (TDEST = {broadcast, global dest port}, TUSER = VLAN), converts the destination into a crossbar egress-port mask, and requests that mask from the crossbar arbiter. Once granted, it streams the frame through a registered skid buffer and releases the grant after the last beat leaves. Frames that are never granted or that carry an invalid destination are discarded and counted.

## Interface

Parameters:
- NUM_PORTS, 50: global switch port count; PORT_BITS = $clog2(NUM_PORTS).
- PORTS_PER_CARD, 24: ports per line card; crossbar port = dest_port / PORTS_PER_CARD.
- NUM_XBAR_PORTS, 3: crossbar port count, equal to the mask width.
- XBAR_PORT, 0: our crossbar port index, driven on m_tid.
- GRANT_TIMEOUT, 1023: cycles to wait in REQUEST before dropping the frame.

Ports:
- clk  in  1  fabric clock.
- areset_n  in  1  asynchronous active-low reset.
- s_tvalid / s_tready  in / out  1  input handshake.
- s_tdata  in  64  frame data.
- s_tkeep  in  8  byte enables.
- s_tlast  in  1  end of frame.
- s_tuser  in  12  VLAN ID.
- s_tdest  in  PORT_BITS+1  {broadcast, dest port}.
- req_valid  out  1  crossbar request, level.
- req_mask  out  NUM_XBAR_PORTS  requested egress ports.
- grant  in  1  arbiter grant, sampled only while req_valid=1.
- release  out  1  one-cycle pulse that frees the granted paths.
- m_tvalid / m_tready  out / in  1  output handshake.
- m_tdata  out  64  frame data.
- m_tkeep  out  8  byte enables.
- m_tlast  out  1  end of frame.
- m_tuser  out  12  VLAN ID.
- m_tdest  out  NUM_XBAR_PORTS  egress mask.
- m_tid  out  $clog2(NUM_XBAR_PORTS)  source port, constant XBAR_PORT.
- drop_timeout_count  out  32  saturating count of frames dropped on timeout.
- drop_invalid_count  out  32  saturating count of frames dropped for a bad destination.

## Operation

- States: IDLE, REQUEST, FORWARD, RELEASE, DROP.
- IDLE:
  - s_tready=0.
  - When s_tvalid=1, latch s_tdest and s_tuser. The head beat stays unconsumed.
  - If broadcast=1, mask is all ones.
  - Else if dest < NUM_PORTS, mask is one-hot at dest/PORTS_PER_CARD; go to REQUEST.
  - Else (dest >= NUM_PORTS) go to DROP and increment drop_invalid_count.
- REQUEST:
  - req_valid=1, req_mask held stable, timer counts up from 0.
  - grant=1 goes to FORWARD.
  - Timer reaching GRANT_TIMEOUT without a grant goes to DROP and increments drop_timeout_count.
  - If grant and timeout occur in the same cycle, grant wins.
- FORWARD:
  - req_valid=0.
  - s_tready = !skid_full; skid_full is the registered "2 entries occupied" flag.
  - Accepted beats are pushed into a 2-entry skid buffer. m_tdest and m_tuser come from the latched values.
  - After s_tlast is accepted, s_tready=0 for the remainder of the frame.
  - Go to RELEASE when the beat with m_tlast=1 completes its handshake.
- RELEASE: release=1 for exactly one cycle, then IDLE.
- DROP:
  - s_tready=1; beats are discarded.
  - Go to IDLE on the cycle after s_tlast is accepted. No request and no release are issued.
- Counters saturate at 32'hFFFFFFFF.
- Per-beat output content (m_tdata/m_tkeep/m_tlast) is bit-exact to the input.

## Timing

- Reset (asynchronous assert, synchronous deassert handled upstream): state=IDLE, s_tready=0, req_valid=0, req_mask=0, release=0, m_tvalid=0, m_tdata/m_tkeep/m_tlast/m_tuser/m_tdest=0, both counters=0, skid buffer empty.
- Reset in mid-frame abandons the frame. The arbiter treats req_valid deasserting under reset as an implicit release.
- Head beat valid in IDLE at cycle N: req_valid=1 at N+1.
- grant sampled high at cycle G: s_tready can be 1 at G+1; first m_tvalid at G+2.
- Steady state with m_tready=1: one beat per cycle, 1-cycle input-to-output latency.
- Backpressure: s_tready drops at most one cycle after m_tready drops, and the skid buffer absorbs the in-flight beat with no loss.
- m_* signals are stable while m_tvalid=1 and m_tready=0.
- release is asserted the cycle after the final output handshake. The next frame's req_valid comes no earlier than 2 cycles after release.
- Single-beat frames (tlast on the head beat) are legal in both FORWARD and DROP.

## Test plan

- Unicast dest port 30, VLAN 5, 8-beat frame, grant 3 cycles after req_valid, m_tready=1 -> req_mask=3'b010; output is 8 identical beats with m_tdest=3'b010, m_tuser=5; one release pulse.
- Broadcast flag set with dest 0 -> req_mask=3'b111; frame forwarded intact.
- Dest 55 (non-broadcast) on a 4-beat frame -> no req_valid; 4 beats consumed; drop_invalid_count=1; m_tvalid stays 0.
- Grant never arrives -> DROP after 1023 cycles; drop_timeout_count=1; frame drained; the next frame is requested normally.
- Random m_tready toggling at 50% on a 100-beat frame -> zero lost or duplicated beats; m_* stable while stalled.
- areset_n pulsed low mid-FORWARD -> all outputs return to reset values immediately; the next frame completes cleanly.
